// File: rtl/stage_4_accumulate_if.sv
// Handshake and data bundle from stage_3 (master) to the stage_4 accumulator (slave).
interface stage_4_accumulate_if #(
  parameter int FLOAT_DATA_WIDTH = 32
);
  logic                        start;
  logic [FLOAT_DATA_WIDTH-1:0] to_add_one;
  logic [FLOAT_DATA_WIDTH-1:0] to_add_two;
  logic [FLOAT_DATA_WIDTH-1:0] result;
  logic                        done;
  logic                        busy;
  logic                        overrun;

  modport master (output start, to_add_one, to_add_two, input result, done, busy, overrun);
  modport slave  (input start, to_add_one, to_add_two, output result, done, busy, overrun);
endinterface

// File: rtl/stage_4_accumulate.sv
// Accumulates N_TERMS (a+b) pair sums from stage_3 into one IEEE-754 single result,
// using one shared pipelined fp adder and a single-entry hold buffer for incoming pairs.
module stage_4_accumulate #(
  parameter int         FLOAT_DATA_WIDTH = 32,
  parameter logic [9:0] ADD_LATENCY      = 10'd7,
  parameter logic [7:0] N_TERMS          = 8'd4
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 clk_en,
  stage_4_accumulate_if.slave bus
);
  localparam int W   = FLOAT_DATA_WIDTH;
  localparam int LAT = int'(ADD_LATENCY);

  typedef enum logic [2:0] {S_IDLE, S_ADD_PAIR, S_ACCUM, S_WAIT, S_DONE} state_t;

  state_t           state_reg;
  logic [W-1:0]     buf_a_reg;
  logic [W-1:0]     buf_b_reg;
  logic             buf_full_reg;
  logic [W-1:0]     acc_reg;
  logic [W-1:0]     sum_reg;
  logic [W-1:0]     result_reg;
  logic             done_reg;
  logic             busy_reg;
  logic             overrun_reg;
  logic [9:0]       lat_cnt_reg;
  logic [7:0]       pair_cnt_reg;
  logic [W-1:0]     add_a;
  logic [W-1:0]     add_b;
  logic [W-1:0]     add_out;
  logic [LAT*W-1:0] pipe_reg;
  logic [LAT*W-1:0] pipe_next;
  logic             take_pair;

  // Round-to-nearest-even single-precision add; NaN/Inf operands pass through untouched.
  function automatic logic [31:0] fp_sum(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] a;
    logic [31:0] b;
    logic [26:0] ma;
    logic [26:0] mb;
    logic [27:0] s;
    logic [24:0] m;
    logic        rnd;
    int          e;
    int          d;
    a = x;
    b = y;
    if (x[30:0] < y[30:0]) begin
      a = y;
      b = x;
    end
    if (&a[30:23]) begin
      if (&b[30:23] && a[22:0] == 23'd0 && a[31] != b[31]) return 32'h7FC0_0000;
      return a;
    end
    ma = {|a[30:23], a[22:0], 3'b000};
    mb = {|b[30:23], b[22:0], 3'b000};
    e  = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
    d  = e - ((b[30:23] == 8'd0) ? 1 : int'(b[30:23]));
    // Bits shifted out of the smaller operand collapse into a sticky lsb.
    if (d > 26) mb = {26'd0, |mb};
    else        mb = (mb >> d) | {26'd0, |(mb & ((27'd1 << d) - 27'd1))};
    if (a[31] == b[31]) s = {1'b0, ma} + {1'b0, mb};
    else                s = {1'b0, ma} - {1'b0, mb};
    if (s == 28'd0) return {a[31] & b[31], 31'd0};
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 1;
    end else begin
      for (int i = 0; i < 26; i++) begin
        if (!s[26] && e > 1) begin
          s = s << 1;
          e = e - 1;
        end
      end
    end
    rnd = s[2] & (s[3] | s[1] | s[0]);
    m   = {1'b0, s[26:3]} + {24'd0, rnd};
    if (m[24]) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {a[31], 8'hFF, 23'd0};
    return {a[31], (m[23] ? e[7:0] : 8'd0), m[22:0]};
  endfunction

  // Pair operands are presented straight from the buffer on the cycle the FSM takes them.
  always_comb begin
    add_a = buf_a_reg;
    add_b = buf_b_reg;
    if (state_reg == S_ACCUM) begin
      add_a = acc_reg;
      add_b = sum_reg;
    end
  end

  if (LAT == 1) begin : g_single
    assign pipe_next = fp_sum(add_a, add_b);
  end else begin : g_deep
    assign pipe_next = {pipe_reg[(LAT-1)*W-1:0], fp_sum(add_a, add_b)};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pipe_reg <= '0;
    else if (clk_en) pipe_reg <= pipe_next;
  end

  assign add_out   = pipe_reg[LAT*W-1 -: W];
  assign take_pair = buf_full_reg && (state_reg == S_IDLE || state_reg == S_WAIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      buf_a_reg    <= '0;
      buf_b_reg    <= '0;
      buf_full_reg <= 1'b0;
      acc_reg      <= '0;
      sum_reg      <= '0;
      result_reg   <= '0;
      done_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      overrun_reg  <= 1'b0;
      lat_cnt_reg  <= '0;
      pair_cnt_reg <= '0;
    end else if (clk_en) begin
      done_reg <= 1'b0;
      // A pair leaving the buffer this cycle frees the slot for a simultaneous start.
      if (bus.start) begin
        if (!buf_full_reg || take_pair) begin
          buf_a_reg    <= bus.to_add_one;
          buf_b_reg    <= bus.to_add_two;
          buf_full_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (take_pair) begin
        buf_full_reg <= 1'b0;
      end
      case (state_reg)
        S_IDLE, S_WAIT: begin
          if (buf_full_reg) begin
            state_reg   <= S_ADD_PAIR;
            busy_reg    <= 1'b1;
            lat_cnt_reg <= '0;
          end
        end
        S_ADD_PAIR: begin
          if (lat_cnt_reg == ADD_LATENCY - 10'd1) begin
            sum_reg     <= add_out;
            lat_cnt_reg <= '0;
            state_reg   <= S_ACCUM;
          end else begin
            lat_cnt_reg <= lat_cnt_reg + 10'd1;
          end
        end
        // One extra cycle here: the acc+sum operands are only valid once sum_reg is loaded.
        S_ACCUM: begin
          if (lat_cnt_reg == ADD_LATENCY) begin
            lat_cnt_reg <= '0;
            if (pair_cnt_reg == N_TERMS - 8'd1) begin
              result_reg   <= add_out;
              acc_reg      <= '0;
              pair_cnt_reg <= '0;
              state_reg    <= S_DONE;
            end else begin
              acc_reg      <= add_out;
              pair_cnt_reg <= pair_cnt_reg + 8'd1;
              state_reg    <= S_WAIT;
            end
          end else begin
            lat_cnt_reg <= lat_cnt_reg + 10'd1;
          end
        end
        S_DONE: begin
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.result  = result_reg;
  assign bus.done    = done_reg;
  assign bus.busy    = busy_reg;
  assign bus.overrun = overrun_reg;
endmodule

// File: tb/tb_stage_4_accumulate.sv
// Scoreboard bench: dut1 sums one pair per result, dut2 sums two pairs per result.
module tb_stage_4_accumulate;
  localparam int LAT      = 7;
  localparam int PAIR_LAT = 2*LAT + 3;

  localparam logic [31:0] F_HALF = 32'h3F00_0000;
  localparam logic [31:0] F_1    = 32'h3F80_0000;
  localparam logic [31:0] F_2    = 32'h4000_0000;
  localparam logic [31:0] F_3    = 32'h4040_0000;
  localparam logic [31:0] F_4    = 32'h4080_0000;
  localparam logic [31:0] F_6    = 32'h40C0_0000;
  localparam logic [31:0] F_8    = 32'h4100_0000;
  localparam logic [31:0] F_M1   = 32'hBF80_0000;
  localparam logic [31:0] F_M2   = 32'hC000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en1 = 1'b1;
  logic en2 = 1'b1;

  always #5 clk = ~clk;

  stage_4_accumulate_if #(.FLOAT_DATA_WIDTH(32)) bus1 ();
  stage_4_accumulate_if #(.FLOAT_DATA_WIDTH(32)) bus2 ();

  stage_4_accumulate #(.FLOAT_DATA_WIDTH(32), .ADD_LATENCY(10'd7), .N_TERMS(8'd1)) u_dut1 (
    .clk(clk), .rst(rst), .clk_en(en1), .bus(bus1)
  );
  stage_4_accumulate #(.FLOAT_DATA_WIDTH(32), .ADD_LATENCY(10'd7), .N_TERMS(8'd2)) u_dut2 (
    .clk(clk), .rst(rst), .clk_en(en2), .bus(bus2)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int done_cnt1   = 0;
  int done_cnt2   = 0;
  int done_cyc1   = 0;
  int done_cyc2   = 0;
  logic [31:0] exp_q1[$];
  logic [31:0] exp_q2[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int which, input logic [31:0] a, input logic [31:0] b,
                      output int edge_no);
    edge_no = cyc + 1;
    if (which == 1) begin
      bus1.start = 1'b1; bus1.to_add_one = a; bus1.to_add_two = b;
    end else begin
      bus2.start = 1'b1; bus2.to_add_one = a; bus2.to_add_two = b;
    end
    tick();
    bus1.start = 1'b0;
    bus2.start = 1'b0;
  endtask

  task automatic wait_done(input int which, input int target, input int budget);
    int seen;
    seen = 0;
    for (int i = 0; i < budget && seen == 0; i++) begin
      tick();
      seen = (((which == 1) ? done_cnt1 : done_cnt2) >= target) ? 1 : 0;
    end
    check($sformatf("dut%0d_done_%0d_seen", which, target), seen, 1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (bus1.done === 1'b1) begin
        done_cnt1++;
        done_cyc1 = cyc;
        $display("dut1 txn %0d result=%h cycle=%0d", done_cnt1, bus1.result, cyc);
        if (exp_q1.size() == 0) check("dut1_unexpected_done", {31'd0, bus1.done}, 32'd0);
        else check("dut1_result", bus1.result, exp_q1.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus2.done === 1'b1) begin
        done_cnt2++;
        done_cyc2 = cyc;
        $display("dut2 txn %0d result=%h cycle=%0d", done_cnt2, bus2.result, cyc);
        if (exp_q2.size() == 0) check("dut2_unexpected_done", {31'd0, bus2.done}, 32'd0);
        else check("dut2_result", bus2.result, exp_q2.pop_front());
      end
    end
  end

  initial begin
    int s;
    int t;
    int n0;
    int first;
    bus1.start = 1'b0; bus1.to_add_one = '0; bus1.to_add_two = '0;
    bus2.start = 1'b0; bus2.to_add_one = '0; bus2.to_add_two = '0;
    tick(3);
    check("rst_result", bus1.result, 32'd0);
    check("rst_done", {31'd0, bus1.done}, 32'd0);
    check("rst_busy", {31'd0, bus1.busy}, 32'd0);
    check("rst_overrun", {31'd0, bus2.overrun}, 32'd0);
    rst = 1'b1;
    tick(2);

    // single pair, N_TERMS=1
    send(1, F_1, F_2, s);
    exp_q1.push_back(F_3);
    tick();
    check("t1_busy", {31'd0, bus1.busy}, 32'd1);
    wait_done(1, 1, 60);
    check("t1_latency", done_cyc1 - s, PAIR_LAT);

    // two pairs, N_TERMS=2: no done after the first
    send(2, F_1, F_2, s);
    tick(18);
    check("t2_no_early_done", done_cnt2, 0);
    send(2, F_HALF, F_HALF, t);
    exp_q2.push_back(F_4);
    wait_done(2, 1, 60);
    check("t2_latency", done_cyc2 - t, PAIR_LAT);

    // three back-to-back strobes: third is dropped
    s = cyc + 1;
    bus2.start = 1'b1; bus2.to_add_one = F_1; bus2.to_add_two = F_1;
    tick();
    bus2.to_add_one = F_2; bus2.to_add_two = F_2;
    tick();
    check("t3_overrun_pre", {31'd0, bus2.overrun}, 32'd0);
    bus2.to_add_one = F_8; bus2.to_add_two = F_8;
    tick();
    bus2.start = 1'b0;
    exp_q2.push_back(F_6);
    check("t3_overrun", {31'd0, bus2.overrun}, 32'd1);
    wait_done(2, 2, 120);
    check("t3_latency", done_cyc2 - s, 4*LAT + 5);
    tick(40);
    check("t3_no_extra_done", done_cnt2, 2);

    // clk_en low for 5 cycles during ADD_PAIR
    n0 = done_cnt1;
    send(1, F_1, F_2, s);
    exp_q1.push_back(F_3);
    tick(2);
    en1 = 1'b0;
    tick(5);
    en1 = 1'b1;
    wait_done(1, n0 + 1, 80);
    check("t4_latency", done_cyc1 - s, PAIR_LAT + 5);

    // reset in the middle of ACCUM
    send(1, F_1, F_2, s);
    tick(LAT + 3);
    check("t5_busy_pre", {31'd0, bus1.busy}, 32'd1);
    check("t5_result_pre", bus1.result, F_3);
    n0 = done_cnt1;
    rst = 1'b0;
    #1;
    check("t5_rst_result", bus1.result, 32'd0);
    check("t5_rst_busy", {31'd0, bus1.busy}, 32'd0);
    check("t5_rst_overrun", {31'd0, bus2.overrun}, 32'd0);
    tick(3);
    rst = 1'b1;
    tick(30);
    check("t5_no_done", done_cnt1, n0);
    send(1, F_2, F_2, s);
    exp_q1.push_back(F_4);
    wait_done(1, n0 + 1, 60);
    check("t5_latency", done_cyc1 - s, PAIR_LAT);

    // back-to-back results, second pair buffered while the first is in flight
    n0 = done_cnt1;
    send(1, F_1, F_1, s);
    exp_q1.push_back(F_2);
    tick(3);
    send(1, F_M1, F_M1, t);
    exp_q1.push_back(F_M2);
    wait_done(1, n0 + 1, 60);
    first = done_cyc1;
    check("t6_first_latency", first - s, PAIR_LAT);
    wait_done(1, n0 + 2, 60);
    check("t6_gap", done_cyc1 - first, 2*LAT + 3);
    check("t6_overrun", {31'd0, bus1.overrun}, 32'd0);
    tick(5);
    check("q1_drained", exp_q1.size(), 0);
    check("q2_drained", exp_q2.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
